unified_memory_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 33 +++
 rtl/unified_memory_ctrl.sv | 110 +++++++++++
 tb/tb_unified_memory_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory controller.
// Holds the controller FSM encoding, the default fetch filler word and the
// fill-pattern selector values.
package mem_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Word handed to the fetch stage while the array is still being filled.
  localparam logic [15:0] NOP_DEFAULT = 16'hF000;

  // Fill patterns applied after reset.
  localparam int INIT_ZERO  = 0;  // every word cleared
  localparam int INIT_IDENT = 1;  // word i holds i (low DATA_W bits)

endpackage

// File: rtl/mem_array.sv
// Storage array: DATA_W x DEPTH words, one synchronous write, two async reads.
// Latency: reads combinational; a write is visible after the clock edge.
// No backpressure; no reset, so contents are undefined until written.
// Ports: clk; we/waddr/wdata write port; raddr_a/rdata_a and raddr_b/rdata_b
// read ports.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 65536,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/unified_memory_ctrl.sv
// Unified instruction/data memory controller with a post-reset fill sequencer.
// Latency: fetch and load are combinational; stores commit at the clock edge;
// flags are registered one-cycle pulses. No backpressure: stores arriving
// during fill or out of range are discarded and flagged via wr_dropped.
// Ports: clk, reset (sync, active-high); i_addr/i_data fetch port;
// d_addr/d_wdata/d_we/d_rdata data port; init_done, wr_dropped, addr_err status.
module unified_memory_ctrl
  import mem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 65536,
  parameter int                INIT_MODE = INIT_ZERO,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_rdata,
  output logic              init_done,
  output logic              wr_dropped,
  output logic              addr_err
);

  localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;

  logic              i_ok;
  logic              d_ok;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] mem_i;
  logic [DATA_W-1:0] mem_d;

  // A fully populated address space can never be out of range.
  if (DEPTH >= (2 ** ADDR_W)) begin : g_full
    assign i_ok = 1'b1;
    assign d_ok = 1'b1;
  end else begin : g_partial
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    assign i_ok = {1'b0, i_addr} < DEPTH_X;
    assign d_ok = {1'b0, d_addr} < DEPTH_X;
  end

  // Write port is owned by the fill sequencer in INIT and by stores in READY.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = d_addr[IDX_W-1:0];
    wr_dat = d_wdata;
    if (!reset) begin
      if (state == ST_INIT) begin
        wr_en  = 1'b1;
        wr_idx = init_cnt[IDX_W-1:0];
        wr_dat = (INIT_MODE == INIT_IDENT) ? DATA_W'(init_cnt) : '0;
      end else if (d_we && d_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (wr_en),
    .waddr   (wr_idx),
    .wdata   (wr_dat),
    .raddr_a (i_addr[IDX_W-1:0]),
    .rdata_a (mem_i),
    .raddr_b (d_addr[IDX_W-1:0]),
    .rdata_b (mem_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      wr_dropped <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      wr_dropped <= d_we && (!init_done || !d_ok);
      addr_err   <= init_done && (!i_ok || !d_ok);
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_data  = !init_done ? NOP_INSTR : (i_ok ? mem_i : '0);
  assign d_rdata = (init_done && d_ok) ? mem_d : '0;

endmodule

// File: tb/tb_unified_memory_ctrl.sv
// Directed bench for unified_memory_ctrl: two 64-word instances (identity and
// zero fill) driven by the same stimulus, checked with immediate assertions.
module tb_unified_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_addr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_we;

  logic [15:0] i_data_1, d_rdata_1, i_data_0, d_rdata_0;
  logic        init_done_1, wr_dropped_1, addr_err_1;
  logic        init_done_0, wr_dropped_0, addr_err_0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  unified_memory_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(64), .INIT_MODE(1), .NOP_INSTR(16'hF000)
  ) dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_data(i_data_1),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_rdata(d_rdata_1),
    .init_done(init_done_1), .wr_dropped(wr_dropped_1), .addr_err(addr_err_1)
  );

  unified_memory_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(64), .INIT_MODE(0), .NOP_INSTR(16'hF000)
  ) dut0 (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_data(i_data_0),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_rdata(d_rdata_0),
    .init_done(init_done_0), .wr_dropped(wr_dropped_0), .addr_err(addr_err_0)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Releases reset and counts edges until init_done; checks the fill-time view.
  task automatic run_fill(input int drop_at, output int edges);
    int n;
    n = 0;
    while (!init_done_1 && n < 200) begin
      if (n == drop_at) begin
        d_addr  = 16'd3;
        d_wdata = 16'hBEEF;
        d_we    = 1'b1;
      end
      step();
      n++;
      if (n == drop_at + 1) begin
        d_we = 1'b0;
        check("drop_pulse", {15'd0, wr_dropped_1}, 16'd1);
        check("drop_no_addr_err", {15'd0, addr_err_1}, 16'd0);
      end
      if (n == drop_at + 2) check("drop_pulse_end", {15'd0, wr_dropped_1}, 16'd0);
      if (!init_done_1) begin
        check("fill_i_nop", i_data_1, 16'hF000);
        check("fill_d_zero", d_rdata_1, 16'h0000);
      end
    end
    edges = n;
  endtask

  logic [15:0] prog [5];
  logic [15:0] paddr [5];
  int edges;

  initial begin
    reset = 1'b1; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    step();
    step();
    check("rst_init_done", {15'd0, init_done_1}, 16'd0);
    check("rst_wr_dropped", {15'd0, wr_dropped_1}, 16'd0);
    check("rst_addr_err", {15'd0, addr_err_1}, 16'd0);
    check("rst_i_nop", i_data_1, 16'hF000);
    check("rst_d_zero", d_rdata_1, 16'h0000);

    // First fill, interrupted by reset after 30 edges.
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      check("partial_init_done", {15'd0, init_done_1}, 16'd0);
    end
    reset = 1'b1;
    step();
    check("restart_init_done", {15'd0, init_done_1}, 16'd0);
    reset = 1'b0;

    // Full fill, with a store attempted at word 3 partway through.
    run_fill(10, edges);
    check("fill_edges", 16'(edges), 16'd64);
    check("ready_init_done", {15'd0, init_done_1}, 16'd1);
    check("ready_init_done0", {15'd0, init_done_0}, 16'd1);

    d_addr = 16'd37; #1;
    check("ident_37", d_rdata_1, 16'd37);
    check("zero_37", d_rdata_0, 16'd0);
    d_addr = 16'd3; #1;
    check("no_beef_3", d_rdata_1, 16'd3);
    check("no_beef_3_z", d_rdata_0, 16'd0);
    check("ready_addr_err", {15'd0, addr_err_1}, 16'd0);

    // Same-cycle store and fetch of word 5: old value now, new after edge.
    i_addr = 16'd5; d_addr = 16'd5; d_wdata = 16'h1234; d_we = 1'b1; #1;
    check("coll_i_old_z", i_data_0, 16'h0000);
    check("coll_i_old", i_data_1, 16'h0005);
    check("coll_d_old", d_rdata_1, 16'h0005);
    step();
    d_we = 1'b0; #1;
    check("coll_i_new_z", i_data_0, 16'h1234);
    check("coll_i_new", i_data_1, 16'h1234);
    check("coll_d_new", d_rdata_0, 16'h1234);
    check("coll_no_drop", {15'd0, wr_dropped_1}, 16'd0);

    // Out-of-range store: 100 would alias to 36 if bounds were ignored.
    d_addr = 16'd100; d_wdata = 16'hDEAD; d_we = 1'b1; #1;
    check("oor_d_zero", d_rdata_1, 16'h0000);
    step();
    d_we = 1'b0; d_addr = 16'd36; #1;
    check("oor_addr_err", {15'd0, addr_err_1}, 16'd1);
    check("oor_wr_dropped", {15'd0, wr_dropped_1}, 16'd1);
    check("oor_no_alias", d_rdata_1, 16'd36);
    step();
    check("oor_addr_err_end", {15'd0, addr_err_1}, 16'd0);
    check("oor_drop_end", {15'd0, wr_dropped_1}, 16'd0);

    // Out-of-range fetch alone.
    i_addr = 16'd64; #1;
    check("oor_i_zero", i_data_1, 16'h0000);
    step();
    i_addr = 16'd0;
    check("oor_i_addr_err", {15'd0, addr_err_1}, 16'd1);
    check("oor_i_no_drop", {15'd0, wr_dropped_1}, 16'd0);
    step();
    check("oor_i_err_end", {15'd0, addr_err_1}, 16'd0);

    // Whole array still holds the fill pattern apart from word 5.
    for (int a = 0; a < 64; a++) begin
      d_addr = 16'(a); #1;
      check("dump_ident", d_rdata_1, (a == 5) ? 16'h1234 : 16'(a));
      check("dump_zero", d_rdata_0, (a == 5) ? 16'h1234 : 16'h0000);
    end

    // Load a short ADD/BEQ/JAL program through the store port, then fetch it.
    prog[0] = 16'h0123; paddr[0] = 16'd0;   // ADD
    prog[1] = 16'h4456; paddr[1] = 16'd1;   // ADD
    prog[2] = 16'h8122; paddr[2] = 16'd2;   // BEQ
    prog[3] = 16'hC00F; paddr[3] = 16'd3;   // JAL to 15
    prog[4] = 16'hC000; paddr[4] = 16'd15;  // JAL to 0
    for (int p = 0; p < 5; p++) begin
      d_addr = paddr[p]; d_wdata = prog[p]; d_we = 1'b1;
      step();
    end
    d_we = 1'b0; d_addr = 16'd0;
    for (int p = 0; p < 5; p++) begin
      i_addr = paddr[p]; #1;
      check("prog_fetch", i_data_1, prog[p]);
      check("prog_fetch_z", i_data_0, prog[p]);
    end
    step();
    check("prog_no_err", {15'd0, addr_err_1}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
